// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// State encoding and the default operand width live here so the top
// level and any future wrappers agree on them.
package mul_seq_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_seq_add.sv
// Combinational WIDTH-bit ripple adder with carry in/out, used for the
// accumulate step of the multiplier.
module add_nbit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  // Zero-extend both operands so the carry-out lands in the top bit.
  always_comb begin
    {co, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential unsigned multiplier: one multiplier bit per clock using a
// shift-and-add datapath of {carry, accumulator, multiplier}.
// Optional feature macro: MUL_SEQ_EARLY_TERM_EN -- finish as soon as the
// remaining unshifted multiplier bits are all zero, aligning the result.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t                state;
  state_t                state_next;

  logic [WIDTH-1:0]      mcand;
  logic [WIDTH-1:0]      acc;
  logic [WIDTH-1:0]      mplier;
  logic [CW-1:0]         count;

  logic                  load;
  logic                  last;

  logic [WIDTH-1:0]      sum;
  logic                  carry;
  logic [WIDTH:0]        add_res;
  logic [2*WIDTH:0]      wide;
  logic [WIDTH-1:0]      step_acc;
  logic [WIDTH-1:0]      step_mplier;
  logic [2*WIDTH-1:0]    result;
`ifdef MUL_SEQ_EARLY_TERM_EN
  logic [WIDTH-1:0]      rem_mask;
`endif

  add_nbit #(
    .WIDTH (WIDTH)
  ) u_add (
    .a  (acc),
    .b  (mcand),
    .ci (1'b0),
    .s  (sum),
    .co (carry)
  );

  // One shift-and-add step; the multiplier register fills from the top
  // with low product bits as its own bits are consumed from the bottom.
  always_comb begin
    add_res     = mplier[0] ? {carry, sum} : {1'b0, acc};
    wide        = {add_res, mplier};
    step_acc    = wide[2*WIDTH:WIDTH+1];
    step_mplier = wide[WIDTH:1];
`ifdef MUL_SEQ_EARLY_TERM_EN
    // After this step the low (count-1) bits of step_mplier are the
    // multiplier bits still to be consumed; if all are zero, the rest of
    // the run would only shift, so do those shifts in one go instead.
    rem_mask = '1;
    rem_mask = ~(rem_mask << (count - CW'(1)));
    last     = (count == CW'(1)) || ((step_mplier & rem_mask) == '0);
    result   = {step_acc, step_mplier} >> (count - CW'(1));
`else
    last     = (count == CW'(1));
    result   = {step_acc, step_mplier};
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers: capture on accept, step while running, publish
  // the result only on the finishing step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      count   <= '0;
      product <= '0;
    end else if (load) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      count  <= CW'(WIDTH);
    end else if (state == RUN) begin
      acc    <= step_acc;
      mplier <= step_mplier;
      count  <= count - CW'(1);
      if (last) begin
        product <= result;
      end
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: the driver pushes expected product and
// latency when it issues a start; a monitor checks done, product, busy
// and product hold behaviour on every falling edge.
module tb_mul_seq;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  typedef struct {
    logic [2*W-1:0] p;
    int             cap;
    int             lat;
  } exp_t;

  exp_t           sb[$];
  logic [2*W-1:0] last_product;
  int             cyc;
  int             tests;
  int             fails;

  mul_seq #(
    .WIDTH (W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a_in),
    .b       (b_in),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_lat(input logic [W-1:0] y);
    int h;
    h = 0;
`ifdef MUL_SEQ_EARLY_TERM_EN
    for (int i = 0; i < W; i++) begin
      if (y[i]) h = i + 1;
    end
    if (h < 1) h = 1;
`else
    h = W;
`endif
    return h;
  endfunction

  // Monitor: all expectations come from the scoreboard entries.
  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_busy;
      exp_busy = (sb.size() > 0) && (cyc >= sb[0].cap) && (cyc < sb[0].cap + sb[0].lat);
      check("busy", 32'(busy), 32'(exp_busy));
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("product", 32'(product), 32'(e.p));
          check("latency", 32'(cyc - e.cap), 32'(e.lat));
          last_product = e.p;
        end
      end else begin
        check("product_hold", 32'(product), 32'(last_product));
      end
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit now);
    exp_t e;
    if (!now) @(negedge clk);
    start = 1'b1;
    a_in  = x;
    b_in  = y;
    e.p   = (2*W)'(x) * (2*W)'(y);
    e.cap = cyc + 1;
    e.lat = model_lat(y);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3*W + 6; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    cyc          = 0;
    last_product = '0;
    rst_n        = 1'b0;
    start        = 1'b0;
    a_in         = '0;
    b_in         = '0;

    #3;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-scale operands.
    issue(4'hF, 4'hF, 0); wait_done();
    // Zero operands.
    issue(4'h0, 4'h9, 0); wait_done();
    issue(4'h9, 4'h0, 0); wait_done();

    // Start during RUN must be ignored.
    issue(4'h3, 4'h5, 0);
    @(negedge clk);
    start = 1'b1; a_in = 4'h7; b_in = 4'h7;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reset in the middle of an operation.
    issue(4'h6, 4'h7, 0);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    last_product = '0;
    #1;
    check("midrun_reset_busy", 32'(busy), 32'd0);
    check("midrun_reset_done", 32'(done), 32'd0);
    check("midrun_reset_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'h2, 4'h3, 0); wait_done();

    // Back-to-back with start held through DONE.
    issue(4'h5, 4'h5, 0); wait_done();
    issue(4'h3, 4'h4, 1); wait_done();

    // Operands exercising short multipliers.
    issue(4'hD, 4'h1, 0); wait_done();
    issue(4'hD, 4'h8, 0); wait_done();

    // Randomized operations with occasional chaining and ignored starts.
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      bit           b2b;
      x   = W'($urandom);
      y   = W'($urandom);
      b2b = ($urandom_range(0, 3) == 0);
      issue(x, y, b2b);
      if (model_lat(y) >= 3 && $urandom_range(0, 1) == 1) begin
        start = 1'b1;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        @(negedge clk);
        start = 1'b0;
      end
      wait_done();
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
